// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and load-type helpers for the core-side bus masters.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load may go to the bus only if its type is known and its address is
  // naturally aligned for the access size.
  function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~addr_lo[0];
      F3_LW:         ok = (addr_lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane extraction and sign/zero extension of a 32-bit read word.
module load_align
  import ahb_pkg::*;
(
  input  logic [31:0] hrdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // select the addressed byte/halfword, then extend according to load type
  always_comb begin
    lane_b = hrdata[7:0];
    lane_h = hrdata[15:0];
    data   = hrdata;
    case (addr)
      2'd0:    lane_b = hrdata[7:0];
      2'd1:    lane_b = hrdata[15:8];
      2'd2:    lane_b = hrdata[23:16];
      default: lane_b = hrdata[31:24];
    endcase
    if (addr[1]) lane_h = hrdata[31:16];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  data = {24'h0, lane_b};
      F3_LHU:  data = {16'h0, lane_h};
      default: data = hrdata;
    endcase
  end

endmodule

// File: rtl/ahb_load_master.sv
// Single-outstanding AHB-Lite read initiator for LSU loads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for ld_req; request latched on acceptance
// ST_ADDR | NONSEQ address phase driven until hready
// ST_DATA | data phase; result or bus error captured on hready
// ST_RESP | one-cycle ld_valid with result / error, back to idle
module ahb_load_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  output logic              ld_busy,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              ld_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        f3_r;
  logic [31:0]       data_r;
  logic              err_r;
  logic [31:0]       aligned;
  logic              req_ok;

  assign req_ok = load_ok(ld_funct3, ld_addr[1:0]);

  load_align u_align (
    .hrdata (hrdata),
    .addr   (addr_r[1:0]),
    .funct3 (f3_r),
    .data   (aligned)
  );

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // request latch and result capture; bad requests skip the bus entirely
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_r <= '0;
      f3_r   <= 3'b000;
      data_r <= 32'h0;
      err_r  <= 1'b0;
    end else begin
      if (state == ST_IDLE && ld_req) begin
        addr_r <= ld_addr;
        f3_r   <= ld_funct3;
        data_r <= 32'h0;
        err_r  <= ~req_ok;
      end else if (state == ST_DATA && hready) begin
        data_r <= hresp ? 32'h0 : aligned;
        err_r  <= hresp;
      end
    end
  end

  // next state and outputs, all decoded from registered state only
  always_comb begin
    state_nxt = state;
    ld_busy   = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = 32'h0;
    ld_err    = 1'b0;
    haddr     = '0;
    htrans    = HTRANS_IDLE;
    hsize     = HSIZE_BYTE;
    hwrite    = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_busy = 1'b0;
        if (ld_req) state_nxt = req_ok ? ST_ADDR : ST_RESP;
      end
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = addr_r;
        case (f3_r[1:0])
          2'b00:   hsize = HSIZE_BYTE;
          2'b01:   hsize = HSIZE_HALF;
          default: hsize = HSIZE_WORD;
        endcase
        if (hready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (hready) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ld_valid  = 1'b1;
        ld_data   = data_r;
        ld_err    = err_r;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_load_master.sv
// Directed bench for ahb_load_master with an expected-result scoreboard.
module tb_ahb_load_master;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_busy, ld_valid, ld_err, hwrite;
  logic [31:0] ld_data, haddr, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready, hresp;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ahb_load_master #(.ADDR_W(32)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_funct3 (ld_funct3),
    .ld_busy   (ld_busy),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_err    (ld_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One load: a_wait hready-low cycles in the address phase, d_wait in the
  // data phase; bus_err drives hresp=1 through the whole data phase.
  // exp_lat==1 marks a request that must be rejected without a bus transfer.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input int a_wait, input int d_wait,
                          input logic bus_err, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat, input logic poke);
    exp_t e, p;
    int   e0;
    logic got;
    logic legal;
    legal = (exp_lat > 1);
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = addr; ld_funct3 = f3;
    hrdata = rdata; hresp = 1'b0; hready = (a_wait == 0);
    e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    e0  = cyc;
    got = 1'b0;
    for (int k = 1; k <= 24 && !got; k++) begin
      ld_req  = poke && (k <= 2);
      ld_addr = poke ? 32'h0000_0000 : addr;
      if (!legal) begin
        hready = 1'b1; hresp = 1'b0;
      end else if (k <= a_wait) begin
        hready = 1'b0; hresp = 1'b0;
      end else if (k == a_wait + 1) begin
        hready = 1'b1; hresp = 1'b0;
      end else if (k <= a_wait + 1 + d_wait) begin
        hready = 1'b0; hresp = bus_err;
      end else begin
        hready = 1'b1; hresp = bus_err;
      end
      @(negedge clk);
      if (ld_valid) begin
        got = 1'b1;
        p = sb.pop_front();
        check("ld_data", ld_data, p.data);
        check("ld_err", {31'h0, ld_err}, {31'h0, p.err});
        check("latency", cyc - e0 + 1, p.lat);
        check("resp_htrans", {30'h0, htrans}, 32'h0);
      end else begin
        check("busy", {31'h0, ld_busy}, 32'h1);
        if (legal && k <= a_wait + 1) begin
          check("addr_htrans", {30'h0, htrans}, 32'h2);
          check("addr_haddr", haddr, addr);
          check("addr_hsize", {29'h0, hsize}, {29'h0, 1'b0, f3[1:0]});
        end else begin
          check("data_htrans", {30'h0, htrans}, 32'h0);
        end
        @(posedge clk); #1;
      end
    end
    check("valid_seen", {31'h0, got}, 32'h1);
    ld_req = 1'b0; hready = 1'b1; hresp = 1'b0;
  endtask

  initial begin
    logic any_valid;
    n_rst = 1'b0; ld_req = 1'b0; ld_addr = 32'h0; ld_funct3 = 3'b000;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_htrans", {30'h0, htrans}, 32'h0);
    check("rst_outs", {26'h0, hsize, hwrite, ld_busy, ld_valid}, 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_ld", {ld_data[30:0], ld_err}, 32'h0);
    n_rst = 1'b1;

    run_load(32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 0, 1'b0, 32'hFFFF_FF80, 1'b0, 3, 1'b0);
    run_load(32'h0000_1003, 3'b100, 32'h80FF_1234, 0, 0, 1'b0, 32'h0000_0080, 1'b0, 3, 1'b0);
    run_load(32'h0000_2002, 3'b001, 32'h8001_0000, 0, 0, 1'b0, 32'hFFFF_8001, 1'b0, 3, 1'b0);
    run_load(32'h0000_2002, 3'b101, 32'h8001_0000, 0, 0, 1'b0, 32'h0000_8001, 1'b0, 3, 1'b0);
    run_load(32'h0000_2000, 3'b001, 32'h8001_F00D, 0, 0, 1'b0, 32'hFFFF_F00D, 1'b0, 3, 1'b0);
    run_load(32'h0000_1002, 3'b000, 32'h80FF_1234, 0, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
    run_load(32'h0000_1001, 3'b100, 32'h80FF_1234, 0, 0, 1'b0, 32'h0000_0012, 1'b0, 3, 1'b0);
    run_load(32'h0000_3000, 3'b010, 32'hDEAD_BEEF, 2, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 8, 1'b0);
    run_load(32'h0000_1002, 3'b010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
    run_load(32'h0000_1000, 3'b011, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
    run_load(32'h0000_2001, 3'b001, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
    run_load(32'h0000_0004, 3'b001, 32'h1234_5678, 0, 1, 1'b1, 32'h0000_0000, 1'b1, 4, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_req_dropped", {31'h0, ld_busy}, 32'h0);

    // reset while the data phase is stalled
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = 32'h0000_4000; ld_funct3 = 3'b010; hready = 1'b1;
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(posedge clk); #1;
    hready = 1'b0;
    check("pre_rst_busy", {31'h0, ld_busy}, 32'h1);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_htrans", {30'h0, htrans}, 32'h0);
    check("mid_rst_outs", {26'h0, hsize, hwrite, ld_busy, ld_valid}, 32'h0);
    check("mid_rst_data", ld_data | {31'h0, ld_err}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1; hready = 1'b1;
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_valid = any_valid | ld_valid;
    end
    check("no_stale_valid", {31'h0, any_valid}, 32'h0);
    run_load(32'h0000_5000, 3'b010, 32'h1234_5678, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 3, 1'b0);
    check("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_load_master.md
# ahb_load_master

Core-side AHB-Lite read initiator for the data-memory path. Accepts one load request at a time from the load/store unit, drives a single-beat NONSEQ read with the correct HSIZE, waits out slave wait states, then extracts the addressed byte/halfword lane from HRDATA and sign- or zero-extends it to 32 bits. It is the read-direction counterpart of the slave-side store merge logic, and sits between the LSU and the AHB-Lite interconnect.

## Interface
- ADDR_W, 32, address width; data width fixed at 32
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- ld_req  in  1  load request; sampled only when ld_busy=0
- ld_addr  in  ADDR_W  byte address of load
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- ld_busy  out  1  high in every state except IDLE
- ld_valid  out  1  one-cycle result strobe
- ld_data  out  32  extended load result; valid with ld_valid, else 0
- ld_err  out  1  with ld_valid: misaligned/illegal request or bus error
- haddr  out  ADDR_W  AHB address
- htrans  out  2  AHB transfer type (IDLE 2'b00 / NONSEQ 2'b10 only)
- hsize  out  3  {1'b0, funct3[1:0]}
- hwrite  out  1  tied 0
- hrdata  in  32  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response (1 = ERROR)

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: on ld_req, register addr and funct3. Legal and aligned -> ADDR. Illegal funct3, LH with addr[0]=1, or LW with addr[1:0]!=0 -> RESP with error (no bus transfer).
- ADDR: htrans=NONSEQ, haddr/hsize from registered request. Leave for DATA when hready=1; otherwise hold all address-phase outputs stable.
- DATA: htrans=IDLE. Wait for hready=1. On hready=1 with hresp=0, capture the extracted result. On hready=1 with hresp=1 (second cycle of the two-cycle ERROR), flag the error. Cycles with hready=0 (including the first ERROR cycle) only wait. Then -> RESP.
- RESP: ld_valid=1 for exactly one cycle. ld_data is the result (0 on error). ld_err reflects the error flag. Then -> IDLE.
- Lane extraction is little-endian:
  - byte = hrdata[8*addr[1:0] +: 8]
  - half = hrdata[16*addr[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- ld_req while ld_busy=1 is ignored (not queued).

## Timing
- Reset values: state IDLE; all outputs 0 (htrans=IDLE, haddr=0, hsize=0, hwrite=0, ld_valid=0, ld_data=0, ld_err=0, ld_busy=0).
- Zero-wait load:
  - ld_req sampled at edge 0.
  - ADDR during cycle 1.
  - DATA during cycle 2 (hrdata sampled).
  - ld_valid during cycle 3.
  - Latency 3 cycles; each extra hready=0 cycle adds 1.
- Error request (illegal/misaligned): ld_valid in cycle 1; htrans never leaves IDLE.
- Back-to-back: the next ld_req is accepted in the IDLE cycle after RESP. Peak throughput is one load per 4 cycles.
- All outputs are registered or decoded from registered state only; no combinational path from hrdata/hready to any output.
- Reset mid-transaction: state returns to IDLE and htrans to IDLE asynchronously. No ld_valid is produced for the abandoned load.

## Structure
- Shared package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE_BYTE/HALF/WORD constants
  - load funct3 constants (LB, LH, LW, LBU, LHU)
- FSM state enum is local to the module.
- One combinational sub-module, load_align:
  - inputs: hrdata, addr[1:0], funct3
  - output: 32-bit extended data
  - reusable by other read paths.

## Test plan
- LB at 0x0000_1003, hrdata=0x80FF_1234, hready=1 -> ld_valid in cycle 3, ld_data=0xFFFF_FF80, ld_err=0, hsize=000; repeat as LBU -> 0x0000_0080.
- LH at 0x0000_2002, hrdata=0x8001_0000 -> 0xFFFF_8001; LHU -> 0x0000_8001; hsize=001.
- LW at 0x0000_3000, hready low 2 cycles in ADDR and 3 in DATA, hrdata=0xDEAD_BEEF:
  - ld_valid in cycle 8, data 0xDEAD_BEEF
  - haddr/htrans stable throughout ADDR.
- LW at 0x0000_1002 or funct3=011 -> ld_valid+ld_err in cycle 1, ld_data=0, htrans stays IDLE.
- LH at 0x0000_0004 with slave ERROR (hready=0/hresp=1, then hready=1/hresp=1) -> ld_valid with ld_err=1, ld_data=0; ld_req pulses during busy are ignored.
- n_rst asserted during DATA -> htrans=IDLE and all outputs 0 immediately; after release, no stale ld_valid, and a new LW completes normally.
